// File: rtl/adc_serial_reader.sv
// adc_serial_reader
// Drives a 3-wire serial ADC (CS_n / SCLK / SDO) and reads 8-bit samples MSB-first.
// Each completed sample appears on adc_out with a one-cycle sample_valid strobe.
// The sample is then held until the next frame completes.
// CLK_DIV sets the SCLK half-period and the CS setup time, in clk cycles.
// GAP sets how long CS_n stays high between frames.

module adc_serial_reader #(
   parameter int CLK_DIV = 4,
   parameter int GAP     = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       adc_sdo,
   output logic       adc_cs_n,
   output logic       adc_sclk,
   output logic [7:0] adc_out,
   output logic       sample_valid,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_HI,
      SHIFT_LO,
      GAP_WAIT
   } state_t;

   // Terminal counts are sized to the 8-bit counters so the compares match widths.
   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
   localparam logic [7:0] GapLast = 8'(GAP);

   state_t     state_q;
   logic [7:0] cnt_q;
   logic [7:0] bitCnt_q;
   logic [7:0] shift_q;
   logic       csN_q;
   logic       sclk_q;
   logic [7:0] out_q;
   logic       valid_q;
   logic       busy_q;

   // Frame sequencer.
   // Every output is a flop written here, so the pins never glitch.
   // cnt_q times both the SCLK half-periods and the inter-frame gap.
   // The gap runs 0..GAP inclusive. The extra count is the edge that starts the next frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         bitCnt_q <= 8'd0;
         shift_q  <= 8'd0;
         csN_q    <= 1'b1;
         sclk_q   <= 1'b0;
         out_q    <= 8'd0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               csN_q  <= 1'b1;
               busy_q <= 1'b0;
               sclk_q <= 1'b0;
               cnt_q  <= 8'd0;
               if (en) begin
                  state_q  <= SETUP;
                  csN_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  bitCnt_q <= 8'd0;
               end
            end
            SETUP, SHIFT_LO: begin
               if (cnt_q == DivLast) begin
                  cnt_q    <= 8'd0;
                  sclk_q   <= 1'b1;
                  shift_q  <= {shift_q[6:0], adc_sdo};
                  bitCnt_q <= bitCnt_q + 8'd1;
                  state_q  <= SHIFT_HI;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            SHIFT_HI: begin
               if (cnt_q == DivLast) begin
                  cnt_q  <= 8'd0;
                  sclk_q <= 1'b0;
                  if (bitCnt_q == 8'd8) begin
                     csN_q   <= 1'b1;
                     busy_q  <= 1'b0;
                     out_q   <= shift_q;
                     valid_q <= 1'b1;
                     state_q <= GAP_WAIT;
                  end else begin
                     state_q <= SHIFT_LO;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            GAP_WAIT: begin
               if (cnt_q == GapLast) begin
                  cnt_q <= 8'd0;
                  if (en) begin
                     state_q  <= SETUP;
                     csN_q    <= 1'b0;
                     busy_q   <= 1'b1;
                     bitCnt_q <= 8'd0;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               csN_q   <= 1'b1;
               busy_q  <= 1'b0;
               sclk_q  <= 1'b0;
               cnt_q   <= 8'd0;
            end
         endcase
      end
   end

   assign adc_cs_n     = csN_q;
   assign adc_sclk     = sclk_q;
   assign adc_out      = out_q;
   assign sample_valid = valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_adc_serial_reader.sv
// Testbench for adc_serial_reader.
// dut0 uses the default timing (CLK_DIV=4, GAP=16).
// dut1 uses the fastest timing (CLK_DIV=1, GAP=1).
// Each DUT is driven by a behavioural ADC model: the MSB is presented when CS_n falls,
// and each later bit follows an SCLK falling edge.

module tb_adc_serial_reader;

   logic clk = 1'b0;
   logic reset = 1'b0;

   logic       en0 = 1'b0, sdo0, csN0, sclk0, valid0, busy0;
   logic [7:0] out0;
   logic       en1 = 1'b0, sdo1, csN1, sclk1, valid1, busy1;
   logic [7:0] out1;

   logic [7:0] adcData0 = 8'd0, cur0 = 8'd0;
   logic [7:0] adcData1 = 8'd0, cur1 = 8'd0;
   int idx0 = 7, idx1 = 7;

   int checks = 0;
   int errors = 0;
   int busyErr = 0;
   int holdErr = 0;
   logic [7:0] prevOut0 = 8'd0, prevOut1 = 8'd0;

   adc_serial_reader #(.CLK_DIV(4), .GAP(16)) dut0 (
      .clk(clk), .reset(reset), .en(en0), .adc_sdo(sdo0),
      .adc_cs_n(csN0), .adc_sclk(sclk0), .adc_out(out0),
      .sample_valid(valid0), .busy(busy0)
   );

   adc_serial_reader #(.CLK_DIV(1), .GAP(1)) dut1 (
      .clk(clk), .reset(reset), .en(en1), .adc_sdo(sdo1),
      .adc_cs_n(csN1), .adc_sclk(sclk1), .adc_out(out1),
      .sample_valid(valid1), .busy(busy1)
   );

   // 10 ns system clock
   always #5 clk = ~clk;

   // ADC model for dut0: latch the word and present its MSB when CS_n falls
   always @(negedge csN0) begin
      cur0 = adcData0;
      idx0 = 7;
   end

   // ADC model for dut0: step to the next bit after each SCLK falling edge
   always @(negedge sclk0) begin
      if (idx0 > 0) idx0 = idx0 - 1;
   end

   // ADC model for dut1: latch the word and present its MSB when CS_n falls
   always @(negedge csN1) begin
      cur1 = adcData1;
      idx1 = 7;
   end

   // ADC model for dut1: step to the next bit after each SCLK falling edge
   always @(negedge sclk1) begin
      if (idx1 > 0) idx1 = idx1 - 1;
   end

   assign sdo0 = cur0[idx0];
   assign sdo1 = cur1[idx1];

   // Background monitors.
   // busy must mirror CS_n at all times.
   // adc_out may change only when sample_valid is high, except while reset is held.
   always @(negedge clk) begin
      if (busy0 !== ~csN0) busyErr++;
      if (busy1 !== ~csN1) busyErr++;
      if (reset) begin
         if (out0 !== prevOut0 && valid0 !== 1'b1) holdErr++;
         if (out1 !== prevOut1 && valid1 !== 1'b1) holdErr++;
      end
      prevOut0 = out0;
      prevOut1 = out1;
   end

   task automatic test_reset();
      reset = 1'b0;
      en0 = 1'b0;
      en1 = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (csN0 !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n got %0b expected 1", csN0); end
      checks++; if (sclk0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk got %0b expected 0", sclk0); end
      checks++; if (out0 !== 8'd0) begin errors++; $display("[TB] FAIL reset_adc_out got %0d expected 0", out0); end
      checks++; if (valid0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b expected 0", valid0); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b expected 0", busy0); end
      checks++; if (csN1 !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n_div1 got %0b expected 1", csN1); end
      @(posedge clk); #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (csN0 !== 1'b1) begin errors++; $display("[TB] FAIL idle_no_en_cs_n got %0b expected 1", csN0); end
   endtask

   task automatic test_single_frame();
      int csLow = 0, pulses = 0, valids = 0;
      logic prevS = 1'b0;
      logic [7:0] seen = 8'd0;
      adcData0 = 8'd100;
      @(posedge clk); #1 en0 = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (csN0 === 1'b0) csLow++;
         if (sclk0 === 1'b1 && prevS === 1'b0) pulses++;
         prevS = sclk0;
         if (valid0 === 1'b1) begin
            valids++;
            seen = out0;
            en0 = 1'b0;
         end
      end
      checks++; if (csLow != 64) begin errors++; $display("[TB] FAIL single_cs_low_cycles got %0d expected 64", csLow); end
      checks++; if (pulses != 8) begin errors++; $display("[TB] FAIL single_sclk_pulses got %0d expected 8", pulses); end
      checks++; if (valids != 1) begin errors++; $display("[TB] FAIL single_valid_count got %0d expected 1", valids); end
      checks++; if (seen !== 8'd100) begin errors++; $display("[TB] FAIL single_sample got %0d expected 100", seen); end
      checks++; if (out0 !== 8'd100) begin errors++; $display("[TB] FAIL single_held got %0d expected 100", out0); end
      checks++; if (csN0 !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_cs_n got %0b expected 1", csN0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [3];
      int times [3];
      int n = 0;
      for (int k = 0; k < 3; k++) begin vals[k] = 8'd0; times[k] = 0; end
      adcData0 = 8'd100;
      @(posedge clk); #1 en0 = 1'b1;
      for (int i = 0; i < 400 && n < 3; i++) begin
         @(negedge clk);
         if (valid0 === 1'b1) begin
            vals[n] = out0;
            times[n] = i;
            n++;
            if (n == 1) adcData0 = 8'd200;
            else if (n == 2) adcData0 = 8'd255;
            else en0 = 1'b0;
         end
      end
      en0 = 1'b0;
      checks++; if (n != 3) begin errors++; $display("[TB] FAIL b2b_frame_count got %0d expected 3", n); end
      checks++; if (vals[0] !== 8'd100) begin errors++; $display("[TB] FAIL b2b_sample0 got %0d expected 100", vals[0]); end
      checks++; if (vals[1] !== 8'd200) begin errors++; $display("[TB] FAIL b2b_sample1 got %0d expected 200", vals[1]); end
      checks++; if (vals[2] !== 8'd255) begin errors++; $display("[TB] FAIL b2b_sample2 got %0d expected 255", vals[2]); end
      checks++; if (times[1] - times[0] != 81) begin errors++; $display("[TB] FAIL b2b_period01 got %0d expected 81", times[1] - times[0]); end
      checks++; if (times[2] - times[1] != 81) begin errors++; $display("[TB] FAIL b2b_period12 got %0d expected 81", times[2] - times[1]); end
      repeat (60) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      logic found = 1'b0;
      logic gotValid = 1'b0;
      adcData0 = 8'd255;
      @(posedge clk); #1 en0 = 1'b1;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (csN0 === 1'b0) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("[TB] FAIL rst_frame_start got 0 expected 1"); end
      // Bit 4 is sampled at edge 36 after CS_n falls; SCLK stays high through edge 39.
      repeat (37) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      checks++; if (csN0 !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_cs_n got %0b expected 1", csN0); end
      checks++; if (sclk0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_sclk got %0b expected 0", sclk0); end
      checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %0b expected 0", busy0); end
      checks++; if (valid0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid got %0b expected 0", valid0); end
      checks++; if (out0 !== 8'd0) begin errors++; $display("[TB] FAIL rst_mid_adc_out got %0d expected 0", out0); end
      adcData0 = 8'd200;
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      checks++; if (csN0 !== 1'b0) begin errors++; $display("[TB] FAIL rst_release_first_edge got %0b expected 0", csN0); end
      for (int i = 0; i < 200 && !gotValid; i++) begin
         @(negedge clk);
         if (valid0 === 1'b1) begin
            gotValid = 1'b1;
            en0 = 1'b0;
         end
      end
      en0 = 1'b0;
      checks++; if (!gotValid) begin errors++; $display("[TB] FAIL rst_after_valid got 0 expected 1"); end
      checks++; if (out0 !== 8'd200) begin errors++; $display("[TB] FAIL rst_after_sample got %0d expected 200", out0); end
      repeat (40) @(negedge clk);
   endtask

   task automatic test_en_drop();
      logic found = 1'b0;
      logic prevCs = 1'b0;
      int valids = 0, extraFalls = 0;
      adcData0 = 8'd200;
      @(posedge clk); #1 en0 = 1'b1;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (csN0 === 1'b0) found = 1'b1;
      end
      en0 = 1'b0;
      checks++; if (!found) begin errors++; $display("[TB] FAIL endrop_frame_start got 0 expected 1"); end
      prevCs = csN0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (valid0 === 1'b1) valids++;
         if (prevCs === 1'b1 && csN0 === 1'b0) extraFalls++;
         prevCs = csN0;
      end
      checks++; if (valids != 1) begin errors++; $display("[TB] FAIL endrop_valid_count got %0d expected 1", valids); end
      checks++; if (out0 !== 8'd200) begin errors++; $display("[TB] FAIL endrop_sample got %0d expected 200", out0); end
      checks++; if (extraFalls != 0) begin errors++; $display("[TB] FAIL endrop_extra_frames got %0d expected 0", extraFalls); end
      checks++; if (csN0 !== 1'b1 || busy0 !== 1'b0) begin errors++; $display("[TB] FAIL endrop_idle got cs_n=%0b busy=%0b expected cs_n=1 busy=0", csN0, busy0); end
   endtask

   task automatic test_lsb_msb();
      logic [7:0] vals [2];
      int n = 0, doubles = 0;
      logic prevV = 1'b0;
      vals[0] = 8'h55;
      vals[1] = 8'h55;
      adcData0 = 8'h00;
      @(posedge clk); #1 en0 = 1'b1;
      for (int i = 0; i < 400 && n < 2; i++) begin
         @(negedge clk);
         if (valid0 === 1'b1 && prevV === 1'b1) doubles++;
         prevV = valid0;
         if (valid0 === 1'b1) begin
            vals[n] = out0;
            n++;
            if (n == 1) adcData0 = 8'hFF;
            else en0 = 1'b0;
         end
      end
      en0 = 1'b0;
      @(negedge clk);
      if (valid0 === 1'b1 && prevV === 1'b1) doubles++;
      checks++; if (n != 2) begin errors++; $display("[TB] FAIL lsbmsb_frame_count got %0d expected 2", n); end
      checks++; if (vals[0] !== 8'h00) begin errors++; $display("[TB] FAIL lsbmsb_zero got %02h expected 00", vals[0]); end
      checks++; if (vals[1] !== 8'hFF) begin errors++; $display("[TB] FAIL lsbmsb_ones got %02h expected ff", vals[1]); end
      checks++; if (doubles != 0) begin errors++; $display("[TB] FAIL lsbmsb_valid_width got %0d wide pulses expected 0", doubles); end
      repeat (60) @(negedge clk);
   endtask

   task automatic test_clkdiv1();
      logic [7:0] vals [2];
      int times [2];
      int n = 0, csLow = 0, sclkHigh = 0, pulses = 0;
      logic prevS = 1'b0;
      vals[0] = 8'd0; vals[1] = 8'd0; times[0] = 0; times[1] = 0;
      adcData1 = 8'hA5;
      @(posedge clk); #1 en1 = 1'b1;
      for (int i = 0; i < 200 && n < 2; i++) begin
         @(negedge clk);
         if (n == 0) begin
            if (csN1 === 1'b0) csLow++;
            if (sclk1 === 1'b1) sclkHigh++;
            if (sclk1 === 1'b1 && prevS === 1'b0) pulses++;
         end
         prevS = sclk1;
         if (valid1 === 1'b1) begin
            vals[n] = out1;
            times[n] = i;
            n++;
            if (n == 2) en1 = 1'b0;
         end
      end
      en1 = 1'b0;
      checks++; if (n != 2) begin errors++; $display("[TB] FAIL div1_frame_count got %0d expected 2", n); end
      checks++; if (csLow != 16) begin errors++; $display("[TB] FAIL div1_cs_low_cycles got %0d expected 16", csLow); end
      checks++; if (sclkHigh != 8 || pulses != 8) begin errors++; $display("[TB] FAIL div1_sclk got high=%0d pulses=%0d expected 8 and 8", sclkHigh, pulses); end
      checks++; if (vals[0] !== 8'hA5 || vals[1] !== 8'hA5) begin errors++; $display("[TB] FAIL div1_sample got %02h,%02h expected a5,a5", vals[0], vals[1]); end
      checks++; if (times[1] - times[0] != 18) begin errors++; $display("[TB] FAIL div1_period got %0d expected 18", times[1] - times[0]); end
      repeat (10) @(negedge clk);
   endtask

   task automatic test_monitors();
      checks++; if (busyErr != 0) begin errors++; $display("[TB] FAIL busy_tracks_cs got %0d mismatched cycles expected 0", busyErr); end
      checks++; if (holdErr != 0) begin errors++; $display("[TB] FAIL adc_out_hold got %0d unstrobed changes expected 0", holdErr); end
   endtask

   // Run every scenario in order, then report the totals.
   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_reset_mid_frame();
      test_en_drop();
      test_lsb_msb();
      test_clkdiv1();
      test_monitors();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_serial_reader.md
# adc_serial_reader

Serial-ADC front end that produces the 8-bit `adc_out` temperature sample consumed by the pipeline temperature controller (`PipeTemp`). It repeatedly runs read frames on a 3-wire SPI-style ADC (CS_n / SCLK / SDO), deserialises 8 bits MSB-first, and presents each sample on a parallel bus with a one-cycle valid strobe. The last sample is held between conversions, so the controller always sees a stable value.

## Interface
- `CLK_DIV`, default 4: number of `clk` cycles per SCLK half-period and for CS setup. Legal range 1..255.
- `GAP`, default 16: number of `clk` cycles CS_n stays high between frames. Legal range 1..255.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  conversion enable; level-sensitive.
- `adc_sdo`  in  1  serial data from the ADC.
- `adc_cs_n`  out  1  ADC chip select, active-low.
- `adc_sclk`  out  1  ADC serial clock; idles low.
- `adc_out`  out  8  last completed sample; held until the next frame completes.
- `sample_valid`  out  1  one-cycle pulse when `adc_out` updates.
- `busy`  out  1  high while CS_n is low.

## Operation
- All outputs are registered. Reset values: `adc_cs_n`=1, `adc_sclk`=0, `adc_out`=0, `sample_valid`=0, `busy`=0. FSM resets to IDLE, and all counters and the shift register reset to 0.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP_WAIT.
- IDLE: CS_n=1, SCLK=0. If `en`=1, go to SETUP and drive CS_n low on the same edge.
- SETUP: hold CS_n=0 and SCLK=0 for `CLK_DIV` cycles. Then go to SHIFT_HI and drive SCLK high.
- SHIFT_HI:
  - On the edge that raises SCLK, shift `adc_sdo` into the LSB of the shift register.
  - After `CLK_DIV` cycles, if bit count < 8, drive SCLK low and go to SHIFT_LO.
  - After `CLK_DIV` cycles, if bit count = 8, end the frame. On that edge: SCLK=0, CS_n=1, `adc_out` takes the shift register, `sample_valid`=1. Then go to GAP_WAIT.
- SHIFT_LO: hold SCLK low for `CLK_DIV` cycles, then raise SCLK and return to SHIFT_HI.
- ADC model contract: MSB is valid from CS_n falling. Each later bit changes after an SCLK falling edge.
- GAP_WAIT: CS_n=1 for `GAP` cycles. Then go to SETUP if `en`=1, otherwise IDLE.
- `en` falling mid-frame does not abort the frame. The frame completes and delivers its sample, then the FSM goes to IDLE.
- `sample_valid` is never high for two consecutive cycles.
- `adc_out` changes only on a `sample_valid` cycle.
- Counters are 8 bits wide with no wrap: the half-period counter counts 0..`CLK_DIV`-1 and the bit counter counts 0..8.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). The partial sample is discarded and no `sample_valid` is emitted.

## Timing
- Let D=`CLK_DIV`. CS_n stays low for exactly 16·D cycles per frame: D setup + 7 full SCLK periods (2D each) + final high phase (D).
- Bit k (k=0 is MSB) is sampled at the SCLK rising edge that occurs (D + 2D·k) cycles after CS_n falls.
- `sample_valid` is asserted on the same edge that raises CS_n.
- Steady-state frame period with `en` held high: 16·D + `GAP` + 1 cycles (the +1 is the GAP_WAIT to SETUP transition edge). With defaults this is 81 cycles.
- First conversion after `reset` releases with `en`=1: CS_n falls on the first `clk` edge after release.
- `busy` equals the inverse of CS_n on every cycle.

## Test plan
- Defaults, ADC model returns 100 (8'h64): CS_n is low for exactly 64 cycles and SCLK produces 8 pulses. `adc_out`=100 with one `sample_valid` pulse; `busy` tracks CS_n throughout.
- Back-to-back frames returning 100, 200, 255 with `en` held high: `adc_out` sequence is 100, 200, 255. The valid pulses are 81 cycles apart, and `adc_out` is held between pulses.
- Reset asserted during bit 4 of a 255 frame: outputs go to reset values immediately and `adc_out` stays 0. After release, the next frame returning 200 yields `adc_out`=200.
- `en` dropped during SETUP of a 200 frame: the frame completes and `adc_out`=200. After the GAP, the FSM stays in IDLE with CS_n=1 and no further pulses.
- `CLK_DIV`=1, `GAP`=1, data 8'hA5: CS_n is low for 16 cycles, SCLK toggles every cycle, and `adc_out`=8'hA5. The frame period is 18 cycles.
- Data 0 then 8'hFF: the LSB and MSB are placed correctly, and `sample_valid` is a single-cycle pulse in both frames.
